// File: rtl/regfile_sb.sv
// Two-write / two-read register file with per-register lock bits (scoreboard),
// optional same-cycle write forwarding and an optional hard-wired zero register.
module regfile_sb #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 16,
    parameter int SPECIAL_ADDR = DEPTH - 1,
    parameter bit BYPASS       = 1'b1,
    parameter bit R0_ZERO      = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    input  logic [$clog2(DEPTH)-1:0] raddr2,
    output logic [WIDTH-1:0]         rdata1,
    output logic [WIDTH-1:0]         rdata2,
    output logic                     busy1,
    output logic                     busy2,
    input  logic                     we1,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [$clog2(DEPTH)-1:0] waddr2,
    input  logic [WIDTH-1:0]         wdata1,
    input  logic [WIDTH-1:0]         wdata2,
    input  logic                     lock_en,
    input  logic [$clog2(DEPTH)-1:0] lock_addr,
    output logic                     lock_err,
    output logic [WIDTH-1:0]         special_data,
    output logic [$clog2(DEPTH)-1:0] special_addr
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] lock_q, lock_d;
    logic [DEPTH-1:0] clr_vec, set_vec;
    logic             lock_err_q, lock_err_d;
    logic             w1_ok, w2_ok, lk_ok;

    // Requests aimed at a hard-wired zero register are dropped up front.
    assign w1_ok = we1 && !(R0_ZERO && waddr1 == '0);
    assign w2_ok = we2 && !(R0_ZERO && waddr2 == '0);
    assign lk_ok = lock_en && !(R0_ZERO && lock_addr == '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lock
            assign clr_vec[gi] = (w1_ok && waddr1 == AW'(gi)) || (w2_ok && waddr2 == AW'(gi));
            assign set_vec[gi] = lk_ok && lock_addr == AW'(gi);
            // A same-cycle lock beats the write's release (back-to-back reissue).
            assign lock_d[gi]  = set_vec[gi] || (lock_q[gi] && !clr_vec[gi]);
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (w1_ok) mem_d[waddr1] = wdata1;
        if (w2_ok) mem_d[waddr2] = wdata2;
    end

    assign lock_err_d = lk_ok && lock_q[lock_addr] && !clr_vec[lock_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            lock_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            lock_q     <= lock_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Three read ports: raddr1, raddr2 and the fixed special-register tap.
    logic [2:0][AW-1:0]    rd_addr;
    logic [2:0][WIDTH-1:0] rd_data;
    logic [1:0]            rd_busy;

    assign rd_addr[0] = raddr1;
    assign rd_addr[1] = raddr2;
    assign rd_addr[2] = AW'(SPECIAL_ADDR);

    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            logic hit1, hit2;
            assign hit1 = BYPASS && w1_ok && waddr1 == rd_addr[gi];
            assign hit2 = BYPASS && w2_ok && waddr2 == rd_addr[gi];
            assign rd_data[gi] = (R0_ZERO && rd_addr[gi] == '0) ? '0 :
                                 hit2 ? wdata2 :
                                 hit1 ? wdata1 : mem_q[rd_addr[gi]];
        end
        for (gi = 0; gi < 2; gi++) begin : g_busy
            assign rd_busy[gi] = !(R0_ZERO && rd_addr[gi] == '0) && lock_q[rd_addr[gi]] &&
                                 !(BYPASS && clr_vec[rd_addr[gi]] && !set_vec[rd_addr[gi]]);
        end
    endgenerate

    assign rdata1       = rd_data[0];
    assign rdata2       = rd_data[1];
    assign special_data = rd_data[2];
    assign busy1        = rd_busy[0];
    assign busy2        = rd_busy[1];
    assign lock_err     = lock_err_q;
    assign special_addr = AW'(SPECIAL_ADDR);
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass+zero-reg, and plain) on shared stimulus,
// checked every cycle against an array/rule model plus directed literal checks.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  raddr1, raddr2, waddr1, waddr2, lock_addr;
    logic        we1, we2, lock_en;
    logic [15:0] wdata1, wdata2;

    logic [15:0] a_rdata1, a_rdata2, a_special, b_rdata1, b_rdata2, b_special;
    logic        a_busy1, a_busy2, a_lock_err, b_busy1, b_busy2, b_lock_err;
    logic [3:0]  a_special_addr, b_special_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance a: BYPASS=1, R0_ZERO=1. Instance b: BYPASS=0, R0_ZERO=0.
    regfile_sb #(.WIDTH(16), .DEPTH(16), .BYPASS(1'b1), .R0_ZERO(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rdata1), .rdata2(a_rdata2),
        .busy1(a_busy1), .busy2(a_busy2),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wdata1(wdata1), .wdata2(wdata2),
        .lock_en(lock_en), .lock_addr(lock_addr), .lock_err(a_lock_err),
        .special_data(a_special), .special_addr(a_special_addr)
    );

    regfile_sb #(.WIDTH(16), .DEPTH(16), .BYPASS(1'b0), .R0_ZERO(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .busy1(b_busy1), .busy2(b_busy2),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wdata1(wdata1), .wdata2(wdata2),
        .lock_en(lock_en), .lock_addr(lock_addr), .lock_err(b_lock_err),
        .special_data(b_special), .special_addr(b_special_addr)
    );

    // Model state, index 0 = instance a, 1 = instance b.
    logic [15:0] m_mem  [2][16];
    bit          m_lock [2][16];
    bit          m_err  [2];
    bit          model_valid = 0;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int r = 0; r < 16; r++) begin
                    m_mem[c][r]  = 16'h0000;
                    m_lock[c][r] = 0;
                end
                m_err[c] = 0;
            end else begin
                bit r0z, v1, v2, vl, cleared;
                r0z = (c == 0);
                v1  = we1 && !(r0z && waddr1 == 0);
                v2  = we2 && !(r0z && waddr2 == 0);
                vl  = lock_en && !(r0z && lock_addr == 0);
                cleared  = (v1 && waddr1 == lock_addr) || (v2 && waddr2 == lock_addr);
                m_err[c] = vl && m_lock[c][lock_addr] && !cleared;
                if (v1) begin m_mem[c][waddr1] = wdata1; m_lock[c][waddr1] = 0; end
                if (v2) begin m_mem[c][waddr2] = wdata2; m_lock[c][waddr2] = 0; end
                if (vl) m_lock[c][lock_addr] = 1;
            end
        end
        if (reset) model_valid = 1;
    end

    function automatic logic [15:0] exp_data(input int c, input logic [3:0] a);
        bit byp = (c == 0);
        bit r0z = (c == 0);
        if (r0z && a == 0) return 16'h0000;
        if (byp && we2 && waddr2 == a) return wdata2;
        if (byp && we1 && waddr1 == a) return wdata1;
        return m_mem[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [3:0] a);
        bit byp = (c == 0);
        bit r0z = (c == 0);
        bit b;
        if (r0z && a == 0) return 1'b0;
        b = m_lock[c][a];
        if (byp && ((we1 && waddr1 == a) || (we2 && waddr2 == a)) && !(lock_en && lock_addr == a))
            b = 0;
        return b;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        cmp(name, act, exp);
        if (act === exp) $display("check %s = %h", name, act);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_valid && !reset) begin
            cmp("a.rdata1", a_rdata1, exp_data(0, raddr1));
            cmp("a.rdata2", a_rdata2, exp_data(0, raddr2));
            cmp("a.busy1", 16'(a_busy1), 16'(exp_busy(0, raddr1)));
            cmp("a.busy2", 16'(a_busy2), 16'(exp_busy(0, raddr2)));
            cmp("a.lock_err", 16'(a_lock_err), 16'(m_err[0]));
            cmp("a.special", a_special, exp_data(0, 4'hF));
            cmp("b.rdata1", b_rdata1, exp_data(1, raddr1));
            cmp("b.rdata2", b_rdata2, exp_data(1, raddr2));
            cmp("b.busy1", 16'(b_busy1), 16'(exp_busy(1, raddr1)));
            cmp("b.busy2", 16'(b_busy2), 16'(exp_busy(1, raddr2)));
            cmp("b.lock_err", 16'(b_lock_err), 16'(m_err[1]));
            cmp("b.special", b_special, exp_data(1, 4'hF));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; lock_en = 0;
    endtask

    initial begin
        reset = 1; idle();
        raddr1 = 0; raddr2 = 0; waddr1 = 0; waddr2 = 0; lock_addr = 0;
        wdata1 = 0; wdata2 = 0;
        step(); step();
        reset = 0;

        // Reset state over every address.
        for (int i = 0; i < 16; i++) begin
            raddr1 = 4'(i); raddr2 = 4'(15 - i);
            #1;
            chk("rst a.rdata1", a_rdata1, 16'h0000);
            chk("rst a.busy1", 16'(a_busy1), 16'h0000);
            chk("rst b.rdata2", b_rdata2, 16'h0000);
            chk("rst b.busy2", 16'(b_busy2), 16'h0000);
            step();
        end
        chk("a.special_addr", 16'(a_special_addr), 16'h000F);
        chk("b.special_addr", 16'(b_special_addr), 16'h000F);
        chk("rst a.special", a_special, 16'h0000);
        chk("rst a.lock_err", 16'(a_lock_err), 16'h0000);

        // Write r3 and observe bypass vs. registered visibility.
        we1 = 1; waddr1 = 3; wdata1 = 16'hA5A5; raddr1 = 3;
        #1;
        chk("byp a.r3", a_rdata1, 16'hA5A5);
        chk("nobyp b.r3 pre", b_rdata1, 16'h0000);
        step(); idle(); #1;
        chk("a.r3 post", a_rdata1, 16'hA5A5);
        chk("b.r3 post", b_rdata1, 16'hA5A5);

        // Write collision on r7: port 2 wins.
        we1 = 1; waddr1 = 7; wdata1 = 16'h1111;
        we2 = 1; waddr2 = 7; wdata2 = 16'h2222; raddr2 = 7;
        #1;
        chk("collide a.byp", a_rdata2, 16'h2222);
        step(); idle(); #1;
        chk("collide a.r7", a_rdata2, 16'h2222);
        chk("collide b.r7", b_rdata2, 16'h2222);

        // Lock r5 twice back to back.
        lock_en = 1; lock_addr = 5; raddr1 = 5;
        #1;
        chk("lock a.busy pre", 16'(a_busy1), 16'h0000);
        step(); #1;
        chk("lock a.busy", 16'(a_busy1), 16'h0001);
        chk("lock a.err 1st", 16'(a_lock_err), 16'h0000);
        step(); idle(); #1;
        chk("relock a.err", 16'(a_lock_err), 16'h0001);
        chk("relock b.err", 16'(b_lock_err), 16'h0001);
        chk("relock a.busy", 16'(a_busy1), 16'h0001);
        step(); #1;
        chk("err pulse end a", 16'(a_lock_err), 16'h0000);
        chk("still locked b", 16'(b_busy1), 16'h0001);

        // Write + lock same register: lock wins, no error.
        we1 = 1; waddr1 = 5; wdata1 = 16'h0F0F; lock_en = 1; lock_addr = 5;
        #1;
        chk("wl a.rdata byp", a_rdata1, 16'h0F0F);
        chk("wl a.busy byp", 16'(a_busy1), 16'h0001);
        step(); idle(); #1;
        chk("wl a.r5", a_rdata1, 16'h0F0F);
        chk("wl b.r5", b_rdata1, 16'h0F0F);
        chk("wl a.busy", 16'(a_busy1), 16'h0001);
        chk("wl a.err", 16'(a_lock_err), 16'h0000);
        chk("wl b.err", 16'(b_lock_err), 16'h0000);
        we1 = 1; waddr1 = 5; wdata1 = 16'h0F0F;
        #1;
        chk("release a.busy byp", 16'(a_busy1), 16'h0000);
        chk("release b.busy pre", 16'(b_busy1), 16'h0001);
        step(); idle(); #1;
        chk("release b.busy", 16'(b_busy1), 16'h0000);
        chk("release a.busy", 16'(a_busy1), 16'h0000);

        // Zero register (instance a) vs. ordinary r0 (instance b).
        we1 = 1; waddr1 = 0; wdata1 = 16'hFFFF; lock_en = 1; lock_addr = 0; raddr1 = 0;
        #1;
        chk("r0 a.byp", a_rdata1, 16'h0000);
        step(); idle(); #1;
        chk("r0 a.rdata", a_rdata1, 16'h0000);
        chk("r0 a.busy", 16'(a_busy1), 16'h0000);
        chk("r0 a.err", 16'(a_lock_err), 16'h0000);
        chk("r0 b.rdata", b_rdata1, 16'hFFFF);
        chk("r0 b.busy", 16'(b_busy1), 16'h0001);
        lock_en = 1; lock_addr = 0;
        step(); idle(); #1;
        chk("r0 relock a.err", 16'(a_lock_err), 16'h0000);
        chk("r0 relock b.err", 16'(b_lock_err), 16'h0001);

        // Short dual-port sweep; the per-cycle compare does the checking.
        for (int i = 0; i < 24; i++) begin
            we1 = i[0]; waddr1 = 4'(i * 3);  wdata1 = 16'(16'h1000 + i);
            we2 = i[1]; waddr2 = 4'(i * 5);  wdata2 = 16'(16'h2000 + i * 7);
            lock_en = (i % 3 == 0); lock_addr = 4'(i * 7);
            raddr1 = 4'(i * 3); raddr2 = 4'(i * 11);
            $display("sweep %0d: we=%b%b wa=%h/%h lock=%b@%h", i, we1, we2, waddr1, waddr2, lock_en, lock_addr);
            step();
        end
        idle();

        // Reset while r15 holds CC89 and another write to r15 is pending.
        we2 = 1; waddr2 = 15; wdata2 = 16'hCC89;
        step(); idle(); #1;
        chk("r15 a.special", a_special, 16'hCC89);
        chk("r15 b.special", b_special, 16'hCC89);
        reset = 1; we2 = 1; waddr2 = 15; wdata2 = 16'h1234; lock_en = 1; lock_addr = 15;
        step(); reset = 0; idle(); raddr1 = 15; raddr2 = 3; #1;
        chk("rst2 a.special", a_special, 16'h0000);
        chk("rst2 b.special", b_special, 16'h0000);
        chk("rst2 b.r15", b_rdata1, 16'h0000);
        chk("rst2 b.busy15", 16'(b_busy1), 16'h0000);
        chk("rst2 a.r3", a_rdata2, 16'h0000);
        chk("rst2 b.err", 16'(b_lock_err), 16'h0000);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
